// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
// Op codes, FSM states and the default operand width / iteration counter width.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int ITER_W   = $clog2(MD_WIDTH);

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIX,
        DONE
    } state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Launch / result bundle between the pipeline controller and the muldiv sequencer.
// master = controller side, slave = sequencer side.
interface muldiv_seq_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, input1, input2,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, input1, input2,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One multiply (shift-add) or restoring-divide iteration on the {upper,lower} working pair.
// Latency: combinational. Backpressure: none, evaluated once per RUN cycle by the sequencer.
// A single WIDTH+1 bit adder/subtractor serves both modes.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] upper,
    input  logic [WIDTH-1:0] lower,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] upper_nxt,
    output logic [WIDTH-1:0] lower_nxt
);
    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic [WIDTH:0] sum;

    always_comb begin
        // divide shifts the dividend MSB into the remainder before the trial subtract
        a_ext     = is_div ? {upper, lower[WIDTH-1]} : {1'b0, upper};
        b_ext     = (is_div || lower[0]) ? {1'b0, opnd} : '0;
        sum       = is_div ? (a_ext - b_ext) : (a_ext + b_ext);
        upper_nxt = sum[WIDTH:1];
        lower_nxt = {sum[0], lower[WIDTH-1:1]};
        if (is_div) begin
            if (!sum[WIDTH]) begin
                upper_nxt = sum[WIDTH-1:0];
                lower_nxt = {lower[WIDTH-2:0], 1'b1};
            end else begin
                upper_nxt = a_ext[WIDTH-1:0];
                lower_nxt = {lower[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// MIPS MULT/MULTU/DIV/DIVU sequencer owning HI/LO; signed ops only with MULDIV_SIGNED_EN defined.
// Latency: done WIDTH+2 cycles after the start edge (1 cycle for divide by zero), data independent.
// Backpressure: none; start is only honoured in IDLE and busy tells the pipeline to stall.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic         clock,
    input  logic         nreset,
    muldiv_seq_if.slave  bus
);
    localparam int              CNT_W = (WIDTH == MD_WIDTH) ? ITER_W : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic               div_q, sgn_q, neg_res_q, neg_rem_q;
    logic [WIDTH-1:0]   a_q, b_q, upper_q, lower_q, opnd_q, hi_q, lo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q, dz_q;

    logic               is_div_req, signed_req, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]   a_abs, b_abs, upper_nxt, lower_nxt, hi_fix, lo_fix;
    logic [2*WIDTH-1:0] prod_neg;

    assign is_div_req = (bus.op == OP_DIVU) || (bus.op == OP_DIV);
`ifdef MULDIV_SIGNED_EN
    assign signed_req = (bus.op == OP_MULT) || (bus.op == OP_DIV);
`else
    assign signed_req = 1'b0;
`endif

    assign a_neg  = sgn_q & a_q[WIDTH-1];
    assign b_neg  = sgn_q & b_q[WIDTH-1];
    assign a_abs  = a_neg ? (~a_q + 1'b1) : a_q;
    assign b_abs  = b_neg ? (~b_q + 1'b1) : b_q;
    assign b_zero = (b_q == '0);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div    (div_q),
        .upper     (upper_q),
        .lower     (lower_q),
        .opnd      (opnd_q),
        .upper_nxt (upper_nxt),
        .lower_nxt (lower_nxt)
    );

    // sign correction applied on the way into HI/LO
    always_comb begin
        prod_neg = ~{upper_q, lower_q} + 1'b1;
        hi_fix   = upper_q;
        lo_fix   = lower_q;
        if (!div_q) begin
            if (neg_res_q) {hi_fix, lo_fix} = prod_neg;
        end else begin
            if (neg_rem_q) hi_fix = ~upper_q + 1'b1;
            if (neg_res_q) lo_fix = ~lower_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = PREP;
            PREP:    state_d = (div_q && b_zero) ? DONE : RUN;
            RUN:     if (cnt_q == LAST) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            div_q     <= 1'b0;
            sgn_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            upper_q   <= '0;
            lower_q   <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= (state_d == DONE);
            dz_q   <= (state_q == PREP) && (state_d == DONE);
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        div_q <= is_div_req;
                        sgn_q <= signed_req;
                        a_q   <= bus.input1;
                        b_q   <= bus.input2;
                    end
                end
                PREP: begin
                    neg_res_q <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                    cnt_q     <= '0;
                    upper_q   <= '0;
                    lower_q   <= div_q ? a_abs : b_abs;
                    opnd_q    <= div_q ? b_abs : a_abs;
                    if (div_q && b_zero) begin
                        hi_q <= a_q;
                        lo_q <= '1;
                    end
                end
                RUN: begin
                    upper_q <= upper_nxt;
                    lower_q <= lower_nxt;
                    cnt_q   <= cnt_q + 1'b1;
                end
                FIX: begin
                    hi_q <= hi_fix;
                    lo_q <= lo_fix;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU; owns the HI/LO register pair.
- Sits beside the single-cycle ALU in EX; the pipeline controller launches an operation and stalls mfhi/mflo consumers on busy.
- Uses iterative shift-add multiply and restoring divide: one bit per cycle, one 33-bit add/sub per iteration.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- nreset  input  1  asynchronous, active-low reset.
- start  input  1  launch request; sampled only in IDLE.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- input1  input  WIDTH  multiplicand / dividend (rs).
- input2  input  WIDTH  multiplier / divisor (rt).
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; HI/LO valid.
- div_by_zero  output  1  high with done when a divide had input2 == 0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Interface: one clock, clock; reset nreset is asynchronous and active-low.
- Reset (async, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0. Reset mid-operation abandons the operation; HI/LO clear.
- FSM transitions:
  - IDLE -> PREP on start; latch op and operands.
  - PREP -> RUN; signed ops take absolute values and record result/remainder signs; DIV/DIVU with input2==0 -> DONE directly.
  - RUN stays WIDTH cycles; counter 0..WIDTH-1; exit to FIX when counter == WIDTH-1.
  - FIX -> DONE; conditional negation.
  - DONE -> IDLE unconditionally.
- Latency: edge E0 samples start; done is high during the cycle after E(WIDTH+2) (34 cycles after E0 for WIDTH=32). Divide-by-zero: done in the cycle after E1. Latency is independent of operand values.
- hi/lo write only on the edge entering DONE; they hold otherwise.
- start outside IDLE, including in DONE, is ignored. Back-to-back issue needs one IDLE cycle.
- Multiply: 64-bit product {hi,lo}. Each RUN cycle adds the multiplicand (33-bit, carry kept) to the upper half when the product LSB is 1, then shifts right 1.
- Divide: restoring. Shift {rem,quo} left 1, trial rem - divisor (33-bit); non-negative result commits and sets the quotient bit. Final lo=quotient, hi=remainder.
- Signed fix:
  - Product negated when operand signs differ.
  - Quotient negated when signs differ; remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0; no trap.
- Divide by zero: lo=all-ones, hi=input1 unchanged, div_by_zero=1 for the done cycle only.
- Outputs done and div_by_zero are registered; busy is decoded from the state register.

Optional Feature:
- Macro MULDIV_SIGNED_EN.
- Defined: op[0] selects signed handling as above.
- Undefined: op[0] is ignored; all ops are unsigned. PREP/FIX stay as no-op states, so latency is identical.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV).
  - state enum (IDLE, PREP, RUN, FIX, DONE).
  - ITER_W = $clog2(WIDTH).
- One combinational sub-module, muldiv_step: the one-iteration datapath (33-bit add/sub, shift, quotient bit, mode select). The top holds the FSM, counter and registers.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after start edge; busy high throughout.
- MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Without MULDIV_SIGNED_EN -> hi=0x00000006, lo=0xFFFFFFEB.
- DIVU 100 / 7 -> lo=14, hi=2. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0x1234 / 0 -> done one cycle after PREP (cycle after E1); div_by_zero=1; lo=0xFFFFFFFF, hi=0x1234.
- start pulsed during RUN and during DONE -> ignored; hi/lo change only once; next start accepted in IDLE.
- nreset low mid-RUN (cycle 10) -> immediate IDLE, busy=0, hi=lo=0, no done pulse; a fresh MULTU 3 x 5 afterwards -> lo=15, hi=0.
